// File: rtl/activate_timer.sv
// Activation-stage sequencer: staircase row enables for one systolic pass,
// followed by a one-cycle done pulse.

module activate_row #(
    parameter int N     = 4,
    parameter int ROW   = 0,
    parameter int CNT_W = 3
) (
    input  logic             run_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             en_o
);
    // Extra bit keeps the window limits from truncating at the top row.
    localparam logic [CNT_W:0] LO = (CNT_W+1)'(ROW);
    localparam logic [CNT_W:0] HI = (CNT_W+1)'(ROW + N - 1);

    logic [CNT_W:0] cnt_x;
    assign cnt_x = {1'b0, cnt_i};

    generate
        if (ROW == 0) begin : g_first
            assign en_o = run_i && (cnt_x <= HI);
        end else begin : g_rest
            assign en_o = run_i && (cnt_x >= LO) && (cnt_x <= HI);
        end
    endgenerate
endmodule

module activate_timer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         clear,
    output logic [N-1:0] act_en,
    output logic         busy,
    output logic         done
);
    localparam int CNT_W = $clog2(2 * N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     act_q, act_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a start in IDLE.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    genvar r;
    generate
        for (r = 0; r < N; r++) begin : g_row
            activate_row #(
                .N    (N),
                .ROW  (r),
                .CNT_W(CNT_W)
            ) u_row (
                .run_i(state_d == RUN),
                .cnt_i(cnt_d),
                .en_o (act_d[r])
            );
        end
    endgenerate

    assign busy_d = (state_d == RUN);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign act_en = act_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_activate_timer.sv
// Scoreboard bench for activate_timer: a pass-elapsed-time model predicts each
// cycle's outputs; a monitor pops and compares after every rising edge.

module tb_activate_timer;
    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] act;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] act_en;
    logic         busy;
    logic         done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_t = -1;
    int   last_rise = -1;
    logic prev_a0 = 1'b0;
    logic track_gap = 1'b0;
    exp_t q[$];

    activate_timer #(.N(N)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start),
        .clear (clear),
        .act_en(act_en),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // t = cycles since the pass began: 0..2N-2 enabled window, 2N-1 done, -1 idle.
    function automatic exp_t expect_of(int t);
        exp_t e;
        e.act  = '0;
        for (int r = 0; r < N; r++)
            e.act[r] = (t >= r) && (t <= r + N - 1) && (t <= 2 * N - 2);
        e.busy = (t >= 0) && (t <= 2 * N - 2);
        e.done = (t == 2 * N - 1);
        return e;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)               m_t = -1;
        else if (clear)           m_t = -1;
        else if (m_t < 0)         m_t = start ? 0 : -1;
        else if (m_t >= 2*N - 1)  m_t = -1;
        else                      m_t = m_t + 1;
        if (clk) q.push_back(expect_of(m_t));
    end

    always begin
        @(posedge clk or negedge n_rst);
        if (clk) begin
            exp_t e;
            #1;
            cyc = cyc + 1;
            if (q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL scoreboard_empty cyc=%0d", cyc);
            end else begin
                e = q.pop_front();
                checks = checks + 1;
                if (act_en !== e.act || busy !== e.busy || done !== e.done) begin
                    failures = failures + 1;
                    $display("FAIL outputs cyc=%0d got act_en=%b busy=%b done=%b want act_en=%b busy=%b done=%b",
                             cyc, act_en, busy, done, e.act, e.busy, e.done);
                end
            end
            if (!track_gap) begin
                last_rise = -1;
            end else if (act_en[0] && !prev_a0) begin
                if (last_rise >= 0) begin
                    checks = checks + 1;
                    if (cyc - last_rise != 9) begin
                        failures = failures + 1;
                        $display("FAIL pass_gap got=%0d want=9", cyc - last_rise);
                    end
                end
                last_rise = cyc;
            end
            prev_a0 = act_en[0];
        end else begin
            #1;
            checks = checks + 1;
            if (act_en !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL async_reset got act_en=%b busy=%b done=%b want all 0",
                         act_en, busy, done);
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1 n_rst = 1'b0;
        cycles(2);
        n_rst = 1'b1;
        cycles(3);

        pulse_start();
        cycles(12);

        track_gap = 1'b1;
        start = 1'b1;
        cycles(20);
        start = 1'b0;
        cycles(10);
        track_gap = 1'b0;

        pulse_start();
        cycles(3);
        pulse_start();
        cycles(10);

        pulse_start();
        cycles(2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cycles(10);
        pulse_start();
        cycles(12);

        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        cycles(3);

        pulse_start();
        cycles(4);
        #2 n_rst = 1'b0;
        cycles(2);
        n_rst = 1'b1;
        cycles(2);
        pulse_start();
        cycles(12);

        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 99) < 30);
            clear = ($urandom_range(0, 99) < 5);
            @(negedge clk);
        end
        start = 1'b0;
        clear = 1'b0;
        cycles(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
